// File: rtl/regfile.sv
// regfile: 32 x XLEN integer register file with a per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle retiring writes to the read ports.
module regfile #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1,
  output logic            rs1_valid,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2,
  output logic            rs2_valid,
  output logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd,
  input  logic            reserve,
  input  logic [4:0]      wreg0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            wen0,
  input  logic [4:0]      wreg1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            wen1
);

  logic [XLEN-1:0]        regs_r [32];
  logic [31:0][CNT_W-1:0] cnt_r;
  logic [31:0]            hit0_s;
  logic [31:0]            hit1_s;
  logic [31:0]            inc_s;
  logic [31:0][1:0]       nwr_s;
  logic [31:0][CNT_W-1:0] cnt_next_s;

  // Decode which registers each strobe touches this cycle; x0 never matches.
  always_comb begin
    hit0_s     = '0;
    hit1_s     = '0;
    inc_s      = '0;
    nwr_s      = '0;
    cnt_next_s = '0;
    for (int i = 1; i < 32; i++) begin
      hit0_s[i]     = wen0 && (wreg0 == 5'(i));
      hit1_s[i]     = wen1 && (wreg1 == 5'(i));
      inc_s[i]      = reserve && (rd == 5'(i));
      nwr_s[i]      = {1'b0, hit0_s[i]} + {1'b0, hit1_s[i]};
      cnt_next_s[i] = cnt_r[i] + CNT_W'(inc_s[i]) - CNT_W'(nwr_s[i]);
    end
  end

  // Register array and scoreboard update; port 0 (younger instruction) wins a write collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= '0;
      end
      cnt_r <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (hit0_s[i]) begin
          regs_r[i] <= wdata0;
        end else if (hit1_s[i]) begin
          regs_r[i] <= wdata1;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
      cnt_r <= cnt_next_s;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [CNT_W-1:0] pend1_s;
  logic [CNT_W-1:0] pend2_s;

  // Read ports see writes retiring on this edge: both the cleared pending count and the data.
  always_comb begin
    pend1_s   = cnt_r[rs1] - CNT_W'(nwr_s[rs1]);
    pend2_s   = cnt_r[rs2] - CNT_W'(nwr_s[rs2]);
    rs1_valid = (rs1 == 5'd0) || (pend1_s == {CNT_W{1'b0}});
    rs2_valid = (rs2 == 5'd0) || (pend2_s == {CNT_W{1'b0}});
    if (rs1 == 5'd0) begin
      rs1_data = '0;
    end else if (hit0_s[rs1]) begin
      rs1_data = wdata0;
    end else if (hit1_s[rs1]) begin
      rs1_data = wdata1;
    end else begin
      rs1_data = regs_r[rs1];
    end
    if (rs2 == 5'd0) begin
      rs2_data = '0;
    end else if (hit0_s[rs2]) begin
      rs2_data = wdata0;
    end else if (hit1_s[rs2]) begin
      rs2_data = wdata1;
    end else begin
      rs2_data = regs_r[rs2];
    end
  end
`else
  // Read ports use registered state only; a retiring value becomes visible one cycle later.
  always_comb begin
    rs1_valid = (rs1 == 5'd0) || (cnt_r[rs1] == {CNT_W{1'b0}});
    rs2_valid = (rs2 == 5'd0) || (cnt_r[rs2] == {CNT_W{1'b0}});
    if (rs1 == 5'd0) begin
      rs1_data = '0;
    end else begin
      rs1_data = regs_r[rs1];
    end
    if (rs2 == 5'd0) begin
      rs2_data = '0;
    end else begin
      rs2_data = regs_r[rs2];
    end
  end
`endif

  regfile_sb_chk #(.CNT_W(CNT_W)) u_sb_chk (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt_r),
    .inc   (inc_s),
    .nwr   (nwr_s)
  );

endmodule

// Scoreboard checker: flags pending-count overflow and writes to a register with too few reservations.
module regfile_sb_chk #(
  parameter int CNT_W = 2
) (
  input logic                   clk,
  input logic                   reset,
  input logic [31:0][CNT_W-1:0] cnt,
  input logic [31:0]            inc,
  input logic [31:0][1:0]       nwr
);

  localparam int WW = CNT_W + 2;
  localparam logic [WW-1:0] CNT_MAX = WW'((2 ** CNT_W) - 1);

  // Check every live register's counter transition at each active edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        assert ({2'b00, cnt[i]} >= WW'(nwr[i]))
          else $error("regfile: write to x%0d with pending count %0d below %0d", i, cnt[i], nwr[i]);
        assert (({2'b00, cnt[i]} + WW'(inc[i])) <= (CNT_MAX + WW'(nwr[i])))
          else $error("regfile: pending count overflow on x%0d", i);
      end
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow the build's bypass setting.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, wreg0, wreg1;
  logic        rs1_valid, rs2_valid, reserve, wen0, wen1;
  logic [31:0] rs1_data, rs2_data, wdata0, wdata1;
  int          checks = 0;
  int          errors = 0;

  regfile #(.XLEN(32), .CNT_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs1       (rs1),
    .rs1_valid (rs1_valid),
    .rs1_data  (rs1_data),
    .rs2       (rs2),
    .rs2_valid (rs2_valid),
    .rs2_data  (rs2_data),
    .rd        (rd),
    .reserve   (reserve),
    .wreg0     (wreg0),
    .wdata0    (wdata0),
    .wen0      (wen0),
    .wreg1     (wreg1),
    .wdata1    (wdata1),
    .wen1      (wen1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; reserve = 1'b0;
    wreg0 = 5'd0; wdata0 = 32'h0; wen0 = 1'b0;
    wreg1 = 5'd0; wdata1 = 32'h0; wen1 = 1'b0;
    tick();
    reset = 1'b0;

    // Reset then read
    rs1 = 5'd5; rs2 = 5'd0; #1;
    chk("rst_rs1_valid", 32'(rs1_valid), 32'd1);
    chk("rst_rs1_data", rs1_data, 32'h0);
    chk("rst_rs2_valid", 32'(rs2_valid), 32'd1);
    chk("rst_rs2_data", rs2_data, 32'h0);

    // Reserve x3; reserve is not visible in its own cycle
    rd = 5'd3; reserve = 1'b1; rs1 = 5'd3; rs2 = 5'd3; #1;
    chk("rsv_same_cycle_valid", 32'(rs1_valid), 32'd1);
    tick();
    reserve = 1'b0; rd = 5'd0; #1;
    chk("rsv_x3_rs1_invalid", 32'(rs1_valid), 32'd0);
    chk("rsv_x3_rs2_invalid", 32'(rs2_valid), 32'd0);

    // Retire x3 through port 1
    wen1 = 1'b1; wreg1 = 5'd3; wdata1 = 32'hDEADBEEF; #1;
    chk("ret_x3_same_valid", 32'(rs1_valid), 32'(BYP));
    chk("ret_x3_same_data", rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    wen1 = 1'b0; #1;
    chk("ret_x3_next_valid", 32'(rs1_valid), 32'd1);
    chk("ret_x3_next_data", rs1_data, 32'hDEADBEEF);
    chk("ret_x3_next_rs2_data", rs2_data, 32'hDEADBEEF);
    tick();
    chk("ret_x3_persist_data", rs1_data, 32'hDEADBEEF);
    chk("ret_x3_persist_valid", 32'(rs2_valid), 32'd1);

    // Double reservation of x7, retired one port at a time
    rd = 5'd7; reserve = 1'b1;
    tick();
    tick();
    reserve = 1'b0; rd = 5'd0; rs1 = 5'd7; rs2 = 5'd7; #1;
    chk("dbl_x7_invalid", 32'(rs1_valid), 32'd0);
    wen0 = 1'b1; wreg0 = 5'd7; wdata0 = 32'h11; #1;
    chk("dbl_x7_first_write_invalid", 32'(rs1_valid), 32'd0);
    tick();
    wen0 = 1'b0;
    chk("dbl_x7_after_first_invalid", 32'(rs1_valid), 32'd0);
    wen1 = 1'b1; wreg1 = 5'd7; wdata1 = 32'h22; #1;
    chk("dbl_x7_second_same_valid", 32'(rs1_valid), 32'(BYP));
    chk("dbl_x7_second_same_data", rs1_data, BYP ? 32'h22 : 32'h11);
    tick();
    wen1 = 1'b0; #1;
    chk("dbl_x7_done_valid", 32'(rs1_valid), 32'd1);
    chk("dbl_x7_done_data", rs1_data, 32'h22);

    // Double reservation of x7, both ports retiring together; port 0 data wins
    rd = 5'd7; reserve = 1'b1;
    tick();
    tick();
    reserve = 1'b0; rd = 5'd0; #1;
    chk("both_x7_invalid", 32'(rs1_valid), 32'd0);
    wen0 = 1'b1; wreg0 = 5'd7; wdata0 = 32'h33;
    wen1 = 1'b1; wreg1 = 5'd7; wdata1 = 32'h44; #1;
    chk("both_x7_same_valid", 32'(rs1_valid), 32'(BYP));
    chk("both_x7_same_data", rs1_data, BYP ? 32'h33 : 32'h22);
    tick();
    wen0 = 1'b0; wen1 = 1'b0; #1;
    chk("both_x7_done_valid", 32'(rs1_valid), 32'd1);
    chk("both_x7_done_data", rs1_data, 32'h33);
    chk("both_x7_done_rs2_valid", 32'(rs2_valid), 32'd1);

    // Simultaneous reserve and write of x9 with count 1
    rd = 5'd9; reserve = 1'b1; rs1 = 5'd9; rs2 = 5'd0;
    tick();
    wen0 = 1'b1; wreg0 = 5'd9; wdata0 = 32'h99; #1;
    chk("x9_rsv_wr_same_valid", 32'(rs1_valid), 32'(BYP));
    chk("x9_rsv_wr_same_data", rs1_data, BYP ? 32'h99 : 32'h0);
    tick();
    reserve = 1'b0; rd = 5'd0; wen0 = 1'b0; #1;
    chk("x9_still_invalid", 32'(rs1_valid), 32'd0);
    chk("x9_array_data", rs1_data, 32'h99);
    wen1 = 1'b1; wreg1 = 5'd9; wdata1 = 32'h9A;
    tick();
    wen1 = 1'b0; #1;
    chk("x9_retired_valid", 32'(rs1_valid), 32'd1);
    chk("x9_retired_data", rs1_data, 32'h9A);

    // x0: reserve and write are ignored
    rd = 5'd0; reserve = 1'b1; wen0 = 1'b1; wreg0 = 5'd0; wdata0 = 32'hFFFFFFFF;
    rs1 = 5'd0; rs2 = 5'd0; #1;
    chk("x0_same_valid", 32'(rs1_valid), 32'd1);
    chk("x0_same_data", rs1_data, 32'h0);
    tick();
    reserve = 1'b0; wen0 = 1'b0; #1;
    chk("x0_next_valid", 32'(rs1_valid), 32'd1);
    chk("x0_next_data", rs1_data, 32'h0);
    chk("x0_next_rs2_data", rs2_data, 32'h0);

    // Reset mid-operation with x4 pending and holding data
    rd = 5'd4; reserve = 1'b1;
    tick();
    tick();
    reserve = 1'b0; rd = 5'd0;
    wen0 = 1'b1; wreg0 = 5'd4; wdata0 = 32'h55;
    tick();
    wen0 = 1'b0; rs2 = 5'd4; rs1 = 5'd3; #1;
    chk("x4_pending_invalid", 32'(rs2_valid), 32'd0);
    chk("x4_pending_data", rs2_data, 32'h55);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("mid_rst_x4_valid", 32'(rs2_valid), 32'd1);
    chk("mid_rst_x4_data", rs2_data, 32'h0);
    chk("mid_rst_x3_data", rs1_data, 32'h0);
    rs1 = 5'd7; #1;
    chk("mid_rst_x7_data", rs1_data, 32'h0);
    chk("mid_rst_x7_valid", 32'(rs1_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry integer register file with an integrated per-register scoreboard for an in-order RISC-V pipeline.
- Instantiated in the decode stage:
  - Two combinational read ports serve rs1/rs2.
  - A reserve strobe marks the decoded instruction's destination register as pending.
  - Two write ports retire results: port 0 from the mem stage, port 1 from the writeback stage.
- The valid flags tell decode whether an operand is ready or whether it must stall.

Parameters:
- XLEN, 32, data width of each register.
- CNT_W, 2, width of each register's pending-write counter (up to 2^CNT_W-1 outstanding writes).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- rs1  input  5  read port 1 address.
- rs1_valid  output  1  read port 1 operand is ready.
- rs1_data  output  XLEN  read port 1 data.
- rs2  input  5  read port 2 address.
- rs2_valid  output  1  read port 2 operand is ready.
- rs2_data  output  XLEN  read port 2 data.
- rd  input  5  register to reserve.
- reserve  input  1  increment rd's pending count at this edge.
- wreg0  input  5  write port 0 address (mem stage).
- wdata0  input  XLEN  write port 0 data.
- wen0  input  1  write port 0 enable.
- wreg1  input  5  write port 1 address (writeback stage).
- wdata1  input  XLEN  write port 1 data.
- wen1  input  1  write port 1 enable.

Behaviour:
- Reset (reset=1 at an edge):
  - All registers become 0 and all pending counts become 0.
  - Writes and reserves in that cycle are ignored.
- x0:
  - Always reads 0 with valid=1.
  - Writes to x0 are ignored; reserve with rd=0 is ignored.
- Pending count per register, with n = number of write ports targeting that register this cycle (wenK & wregK==r & r!=0, so n is 0..2):
  - Next count = count + (reserve & rd==r) - n.
  - Reserve and write of the same register in one cycle leave the count unchanged.
- Counter bounds:
  - The pipeline guarantees the count never overflows or underflows.
  - Simulation assertion on overflow, or on a write to a register with count < n.
- Write order and conflicts:
  - Both ports write on the edge.
  - If wreg0==wreg1 (nonzero) with both enabled, wdata0 wins: the mem stage holds the younger instruction.
- Reads are combinational, rsN_valid = (rsN==0) | (count[rsN] - n[rsN] == 0).
- Read data selection, in priority order:
  - rsN==0 → 0.
  - Port 0 writing rsN this cycle → wdata0.
  - Else port 1 writing rsN this cycle → wdata1.
  - Else the array value.
- A reserve in the current cycle does not affect the current cycle's read outputs; it takes effect from the next cycle.
- Read data when valid=0 is don't-care. The decode stage must not consume it.
- No other latency: one-cycle write, zero-cycle read.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: same-cycle write-to-read bypass exactly as in Behaviour.
- Undefined:
  - rsN_valid = (rsN==0) | (count[rsN]==0), using the registered count only.
  - rsN_data comes from the array only, or 0 for x0.
  - A consumer therefore sees the value one cycle after the retiring write. This costs one extra stall cycle but gives a shorter read path.
- Scoreboard and write semantics are identical in both builds.

Test Plan:
- Reset then read: reset=1 one cycle, then rs1=5, rs2=0 → rs1_valid=1, rs1_data=0, rs2_valid=1, rs2_data=0.
- Reserve/retire: reserve rd=3 → next cycle rs1=3 gives valid=0.
  - Cycle with wen1, wreg1=3, wdata1=0xDEADBEEF: with bypass, rs1_valid=1 and rs1_data=0xDEADBEEF in that same cycle.
  - Without bypass, valid=1 and the data appear the following cycle.
  - Data persists afterwards.
- Double reservation: reserve x7 twice → count 2.
  - wen0 x7=0x11 → still invalid.
  - Next cycle wen1 x7=0x22 → valid, data 0x22.
  - Repeat with both ports writing x7 in the same cycle (0x33 on port 0, 0x44 on port 1) → data 0x33, count 0.
- Simultaneous reserve and write of x9 (count 1): count stays 1, rs1=9 remains invalid; the written value is in the array.
- x0 handling: reserve rd=0, wen0 wreg0=0 wdata0=0xFFFFFFFF → rs1=0 gives valid=1, data=0.
- Reset mid-operation: x4 reserved with data 0x55 stored, assert reset → x4 valid=1, data=0.
